mapper_lrn_stream: RTL and testbench

MAPPER_LRN_STREAM -- requirements
Module: mapper_lrn_stream

---
 rtl/mapper_lrn_stream_if.sv | 40 ++++
 rtl/mapper_lrn_stream.sv | 142 ++++++++++++++
 tb/tb_mapper_lrn_stream.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mapper_lrn_stream_if.sv
// rtl/mapper_lrn_stream_if.sv - configuration, read/write request and status bundle for mapper_lrn_stream
interface mapper_lrn_stream_if #(
  parameter int N_WIDTH        = 2,
  parameter int M_WIDTH        = 10,
  parameter int E_WIDTH        = 6,
  parameter int F_WIDTH        = 6,
  parameter int V_WIDTH        = 2,
  parameter int ADDR_BUS_WIDTH = 20
);
  logic                      start_normalization;
  logic                      abort;
  logic [N_WIDTH-1:0]        dim4;
  logic [M_WIDTH-1:0]        dim3;
  logic [E_WIDTH-1:0]        dim2;
  logic [F_WIDTH-1:0]        dim1;
  logic [V_WIDTH-1:0]        padding_num;
  logic [ADDR_BUS_WIDTH-1:0] r_base;
  logic [ADDR_BUS_WIDTH-1:0] w_base;
  logic                      full_flag;
  logic                      div_out_valid;
  logic [ADDR_BUS_WIDTH-1:0] r_addr;
  logic                      r_enable;
  logic [ADDR_BUS_WIDTH-1:0] w_addr;
  logic                      w_enable;
  logic                      busy;
  logic                      normalized_layer;
  logic                      cfg_err;

  modport master (
    output start_normalization, abort, dim4, dim3, dim2, dim1, padding_num,
           r_base, w_base, full_flag, div_out_valid,
    input  r_addr, r_enable, w_addr, w_enable, busy, normalized_layer, cfg_err
  );

  modport slave (
    input  start_normalization, abort, dim4, dim3, dim2, dim1, padding_num,
           r_base, w_base, full_flag, div_out_valid,
    output r_addr, r_enable, w_addr, w_enable, busy, normalized_layer, cfg_err
  );
endinterface

// File: rtl/mapper_lrn_stream.sv
// rtl/mapper_lrn_stream.sv - LRN tensor walker issuing dense reads and padded writes with bounded read-ahead
module mapper_lrn_stream #(
  parameter int N_WIDTH        = 2,
  parameter int M_WIDTH        = 10,
  parameter int E_WIDTH        = 6,
  parameter int F_WIDTH        = 6,
  parameter int V_WIDTH        = 2,
  parameter int ADDR_BUS_WIDTH = 20,
  parameter int MAX_AHEAD      = 8
) (
  input  logic             core_clk,
  input  logic             reset_n,
  mapper_lrn_stream_if.slave bus
);
  localparam int CW = M_WIDTH + E_WIDTH + F_WIDTH + N_WIDTH;
  localparam int AW = ADDR_BUS_WIDTH;
  localparam logic [CW-1:0] AHEAD = CW'(MAX_AHEAD);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [N_WIDTH-1:0] d4, r4, w4;
  logic [M_WIDTH-1:0] d3, r3, w3;
  logic [E_WIDTH-1:0] d2, r2, w2;
  logic [F_WIDTH-1:0] d1, r1, w1;
  logic [V_WIDTH-1:0] pad;
  logic [AW-1:0]      rb, wb, s3, s4, p2, ps3, ps4;
  logic [AW-1:0]      s3_c, p1_c, p2_c, ps3_c, r_addr_calc, w_addr_calc;
  logic [CW-1:0]      total, rd_cnt, wr_cnt;
  logic               dims_zero, rd_go, wr_go, all_done;

  assign dims_zero = (d1 == '0) || (d2 == '0) || (d3 == '0) || (d4 == '0);
  assign all_done  = (rd_cnt == total) && (wr_cnt == total);

  // Writes may only retire pixels already read, so wr_cnt < rd_cnt gates them.
  assign rd_go = (state == RUN) && !bus.abort && (rd_cnt < total) && !bus.full_flag
                 && ((rd_cnt - wr_cnt) < AHEAD);
  assign wr_go = (state == RUN) && !bus.abort && bus.div_out_valid
                 && (wr_cnt < total) && (wr_cnt < rd_cnt);

  assign s3_c  = AW'(d1) * AW'(d2);
  assign p1_c  = AW'(d1) + (AW'(pad) << 1);
  assign p2_c  = AW'(d2) + (AW'(pad) << 1);
  assign ps3_c = p1_c * p2_c;

  assign r_addr_calc = rb + AW'(r4) * s4 + AW'(r3) * s3 + AW'(r1) * AW'(d2) + AW'(r2);
  assign w_addr_calc = wb + AW'(w4) * ps4 + AW'(w3) * ps3
                       + (AW'(w1) + AW'(pad)) * p2 + AW'(w2) + AW'(pad);

  always_ff @(posedge core_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt            = state;
    bus.busy             = (state != IDLE);
    bus.normalized_layer = (state == DONE);
    case (state)
      IDLE:    if (bus.start_normalization) state_nxt = LOAD;
      LOAD:    state_nxt = (bus.abort || dims_zero) ? IDLE : RUN;
      RUN:     if (bus.abort) state_nxt = IDLE;
               else if (all_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge reset_n) begin
    if (!reset_n) begin
      {d4, r4, w4} <= '0;  {d3, r3, w3} <= '0;
      {d2, r2, w2} <= '0;  {d1, r1, w1} <= '0;
      pad <= '0;  rb <= '0;  wb <= '0;
      s3 <= '0;  s4 <= '0;  p2 <= '0;  ps3 <= '0;  ps4 <= '0;
      total <= '0;  rd_cnt <= '0;  wr_cnt <= '0;
      bus.r_addr <= '0;  bus.w_addr <= '0;
      bus.r_enable <= 1'b0;  bus.w_enable <= 1'b0;  bus.cfg_err <= 1'b0;
    end else begin
      bus.cfg_err  <= 1'b0;
      bus.r_enable <= rd_go;
      bus.w_enable <= wr_go;
      if (rd_go) bus.r_addr <= r_addr_calc;
      if (wr_go) bus.w_addr <= w_addr_calc;
      case (state)
        IDLE: if (bus.start_normalization) begin
          d4 <= bus.dim4;  d3 <= bus.dim3;  d2 <= bus.dim2;  d1 <= bus.dim1;
          pad <= bus.padding_num;  rb <= bus.r_base;  wb <= bus.w_base;
          {r4, r3, r2, r1} <= '0;  {w4, w3, w2, w1} <= '0;
          rd_cnt <= '0;  wr_cnt <= '0;
        end
        LOAD: begin
          if (!bus.abort && dims_zero) bus.cfg_err <= 1'b1;
          total <= CW'(d1) * CW'(d2) * CW'(d3) * CW'(d4);
          s3  <= s3_c;
          s4  <= s3_c * AW'(d3);
          p2  <= p2_c;
          ps3 <= ps3_c;
          ps4 <= ps3_c * AW'(d3);
        end
        RUN: if (bus.abort) begin
          {r4, r3, r2, r1} <= '0;  {w4, w3, w2, w1} <= '0;
          rd_cnt <= '0;  wr_cnt <= '0;
        end else begin
          // Both walks step idx4 fastest, carrying into idx3, idx2, then idx1.
          if (rd_go) begin
            rd_cnt <= rd_cnt + CW'(1);
            if (r4 != d4 - N_WIDTH'(1)) r4 <= r4 + N_WIDTH'(1);
            else begin
              r4 <= '0;
              if (r3 != d3 - M_WIDTH'(1)) r3 <= r3 + M_WIDTH'(1);
              else begin
                r3 <= '0;
                if (r2 != d2 - E_WIDTH'(1)) r2 <= r2 + E_WIDTH'(1);
                else begin
                  r2 <= '0;
                  r1 <= (r1 == d1 - F_WIDTH'(1)) ? '0 : r1 + F_WIDTH'(1);
                end
              end
            end
          end
          if (wr_go) begin
            wr_cnt <= wr_cnt + CW'(1);
            if (w4 != d4 - N_WIDTH'(1)) w4 <= w4 + N_WIDTH'(1);
            else begin
              w4 <= '0;
              if (w3 != d3 - M_WIDTH'(1)) w3 <= w3 + M_WIDTH'(1);
              else begin
                w3 <= '0;
                if (w2 != d2 - E_WIDTH'(1)) w2 <= w2 + E_WIDTH'(1);
                else begin
                  w2 <= '0;
                  w1 <= (w1 == d1 - F_WIDTH'(1)) ? '0 : w1 + F_WIDTH'(1);
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mapper_lrn_stream.sv
// tb/tb_mapper_lrn_stream.sv - directed self-checking bench for mapper_lrn_stream
module tb_mapper_lrn_stream;
  logic clk;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   nl_cnt  = 0;
  int   cfg_cnt = 0;
  logic [19:0] rq[$];
  logic [19:0] wq[$];

  mapper_lrn_stream_if #(.ADDR_BUS_WIDTH(20)) bus ();

  mapper_lrn_stream #(.MAX_AHEAD(4)) dut (
    .core_clk (clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.r_enable) rq.push_back(bus.r_addr);
    if (bus.w_enable) wq.push_back(bus.w_addr);
    if (bus.normalized_layer) nl_cnt++;
    if (bus.cfg_err) cfg_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    rq.delete();
    wq.delete();
    nl_cnt  = 0;
    cfg_cnt = 0;
  endtask

  task automatic start_layer(input int d4, input int d3, input int d2, input int d1,
                             input int pad, input int rb, input int wb);
    bus.dim4 = 2'(d4);  bus.dim3 = 10'(d3);  bus.dim2 = 6'(d2);  bus.dim1 = 6'(d1);
    bus.padding_num = 2'(pad);
    bus.r_base = 20'(rb);  bus.w_base = 20'(wb);
    bus.start_normalization = 1'b1;
    step();
    bus.start_normalization = 1'b0;
  endtask

  task automatic wait_reads(input int n, input string name);
    for (int c = 0; c < 200 && rq.size() < n; c++) step();
    n_tests++;
    if (rq.size() < n) begin
      n_fail++;
      $display("FAIL %s wait_reads: got %0d reads, need %0d", name, rq.size(), n);
    end
  endtask

  task automatic wait_done(input string name);
    for (int c = 0; c < 300 && !(nl_cnt > 0 && !bus.busy); c++) step();
    repeat (3) step();
    n_tests++;
    if (nl_cnt !== 1) begin
      n_fail++;
      $display("FAIL %s normalized_layer pulses: got %0d, need 1", name, nl_cnt);
    end
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) step();
    n_tests++;
    if ({bus.r_enable, bus.w_enable, bus.busy, bus.normalized_layer, bus.cfg_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset flags: got %b, need 00000",
               {bus.r_enable, bus.w_enable, bus.busy, bus.normalized_layer, bus.cfg_err});
    end
    n_tests++;
    if (bus.r_addr !== 20'd0 || bus.w_addr !== 20'd0) begin
      n_fail++;
      $display("FAIL reset addr: got r=%0d w=%0d, need 0 0", bus.r_addr, bus.w_addr);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_address_walk();
    int exp_a[8] = '{0, 4, 1, 5, 2, 6, 3, 7};
    logic [19:0] got;
    clear_obs();
    bus.div_out_valid = 1'b1;
    start_layer(2, 1, 2, 2, 0, 0, 0);
    wait_done("walk");
    bus.div_out_valid = 1'b0;
    n_tests++;
    if (rq.size() != 8 || wq.size() != 8) begin
      n_fail++;
      $display("FAIL walk counts: got r=%0d w=%0d, need 8 8", rq.size(), wq.size());
    end
    for (int i = 0; i < 8; i++) begin
      got = (i < rq.size()) ? rq[i] : 20'hxxxxx;
      n_tests++;
      if (got !== 20'(exp_a[i])) begin
        n_fail++;
        $display("FAIL walk r_addr[%0d]: got %0d, need %0d", i, got, exp_a[i]);
      end
      got = (i < wq.size()) ? wq[i] : 20'hxxxxx;
      n_tests++;
      if (got !== 20'(exp_a[i])) begin
        n_fail++;
        $display("FAIL walk w_addr[%0d]: got %0d, need %0d", i, got, exp_a[i]);
      end
    end
  endtask

  task automatic test_padded_write();
    int exp_w[8] = '{105, 121, 106, 122, 109, 125, 110, 126};
    logic [19:0] got;
    clear_obs();
    bus.div_out_valid = 1'b1;
    start_layer(2, 1, 2, 2, 1, 0, 100);
    wait_done("padded");
    bus.div_out_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = (i < wq.size()) ? wq[i] : 20'hxxxxx;
      n_tests++;
      if (got !== 20'(exp_w[i])) begin
        n_fail++;
        $display("FAIL padded w_addr[%0d]: got %0d, need %0d", i, got, exp_w[i]);
      end
    end
  endtask

  task automatic test_flow_control();
    clear_obs();
    start_layer(3, 8, 4, 4, 0, 0, 0);
    repeat (20) step();
    n_tests++;
    if (rq.size() != 4) begin
      n_fail++;
      $display("FAIL flow ahead limit: got %0d reads, need 4", rq.size());
    end
    n_tests++;
    if (rq.size() >= 4 && (rq[1] !== 20'd128 || rq[2] !== 20'd256 || rq[3] !== 20'd16)) begin
      n_fail++;
      $display("FAIL flow r_addr: got %0d %0d %0d, need 128 256 16", rq[1], rq[2], rq[3]);
    end
    bus.div_out_valid = 1'b1;
    step();
    bus.div_out_valid = 1'b0;
    repeat (10) step();
    n_tests++;
    if (rq.size() != 5 || wq.size() != 1) begin
      n_fail++;
      $display("FAIL flow after one write: got r=%0d w=%0d, need 5 1", rq.size(), wq.size());
    end
    n_tests++;
    if (rq.size() == 5 && rq[4] !== 20'd144) begin
      n_fail++;
      $display("FAIL flow fifth r_addr: got %0d, need 144", rq[4]);
    end
    do_abort();
  endtask

  task automatic test_backpressure();
    int exp_a[8] = '{0, 4, 1, 5, 2, 6, 3, 7};
    int held;
    logic [19:0] got;
    clear_obs();
    bus.div_out_valid = 1'b1;
    start_layer(2, 1, 2, 2, 0, 0, 0);
    wait_reads(3, "stall");
    bus.full_flag = 1'b1;
    held = rq.size();
    repeat (10) step();
    n_tests++;
    if (rq.size() != held) begin
      n_fail++;
      $display("FAIL stall reads during full: got %0d, need %0d", rq.size(), held);
    end
    bus.full_flag = 1'b0;
    wait_done("stall");
    bus.div_out_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = (i < rq.size()) ? rq[i] : 20'hxxxxx;
      n_tests++;
      if (got !== 20'(exp_a[i]) || rq.size() != 8) begin
        n_fail++;
        $display("FAIL stall r_addr[%0d]: got %0d (n=%0d), need %0d", i, got, rq.size(), exp_a[i]);
      end
    end
  endtask

  task automatic test_abort_cfg();
    clear_obs();
    start_layer(3, 8, 4, 4, 0, 0, 0);
    wait_reads(3, "abort");
    do_abort();
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort busy: got %b, need 0", bus.busy);
    end
    repeat (10) step();
    n_tests++;
    if (rq.size() != 3 || nl_cnt != 0) begin
      n_fail++;
      $display("FAIL abort after: got reads=%0d done=%0d, need 3 0", rq.size(), nl_cnt);
    end
    clear_obs();
    start_layer(3, 0, 4, 4, 0, 0, 0);
    repeat (10) step();
    n_tests++;
    if (cfg_cnt != 1 || rq.size() != 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_err: got pulses=%0d reads=%0d busy=%b, need 1 0 0",
               cfg_cnt, rq.size(), bus.busy);
    end
  endtask

  task automatic test_reset_mid_run();
    clear_obs();
    bus.div_out_valid = 1'b1;
    start_layer(3, 8, 4, 4, 0, 50, 0);
    wait_reads(3, "rst");
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.r_enable, bus.w_enable, bus.busy, bus.normalized_layer, bus.cfg_err} !== 5'b0
        || bus.r_addr !== 20'd0 || bus.w_addr !== 20'd0) begin
      n_fail++;
      $display("FAIL rst async: got flags=%b r=%0d w=%0d, need 0 0 0",
               {bus.r_enable, bus.w_enable, bus.busy, bus.normalized_layer, bus.cfg_err},
               bus.r_addr, bus.w_addr);
    end
    bus.div_out_valid = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    clear_obs();
    start_layer(3, 8, 4, 4, 0, 50, 0);
    wait_reads(2, "rst restart");
    n_tests++;
    if (rq.size() >= 2 && (rq[0] !== 20'd50 || rq[1] !== 20'd178)) begin
      n_fail++;
      $display("FAIL rst restart r_addr: got %0d %0d, need 50 178", rq[0], rq[1]);
    end
    do_abort();
  endtask

  initial begin
    reset_n = 1'b0;
    bus.start_normalization = 1'b0;
    bus.abort = 1'b0;
    bus.dim4 = '0;  bus.dim3 = '0;  bus.dim2 = '0;  bus.dim1 = '0;
    bus.padding_num = '0;
    bus.r_base = '0;  bus.w_base = '0;
    bus.full_flag = 1'b0;
    bus.div_out_valid = 1'b0;
    test_reset();
    test_address_walk();
    test_padded_write();
    test_flow_control();
    test_backpressure();
    test_abort_cfg();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
